// File: rtl/maxhpc_fifo_sc_if.sv
`default_nettype none
// ============================================================================
//  Module      : maxhpc_fifo_sc_if
//  Description : Bundle of the write/read handshake, data and status signals
//                of the single-clock FIFO maxhpc_fifo_sc.
//                master = FIFO user (drives wr/d/rd), slave = FIFO itself.
//  Ports       : wr, d, rd               user -> FIFO
//                commit, discard         user -> FIFO (MAXHPC_FIFO_SC_PKT_EN)
//                q, empty, full, usedw,
//                almost_full, almost_empty,
//                ovf, udf                FIFO -> user
//  Options     : MAXHPC_FIFO_SC_PKT_EN adds the commit/discard signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface maxhpc_fifo_sc_if #(
  parameter int DATA_WD  = 8,
  parameter int DEPTH_WD = 4
);
  logic                wr;
  logic [DATA_WD-1:0]  d;
  logic                rd;
  logic [DATA_WD-1:0]  q;
  logic                empty;
  logic                full;
  logic [DEPTH_WD:0]   usedw;
  logic                almost_full;
  logic                almost_empty;
  logic                ovf;
  logic                udf;
`ifdef MAXHPC_FIFO_SC_PKT_EN
  logic                commit;
  logic                discard;
`endif

  modport master (
    output wr, d, rd,
`ifdef MAXHPC_FIFO_SC_PKT_EN
    output commit, discard,
`endif
    input  q, empty, full, usedw, almost_full, almost_empty, ovf, udf
  );

  modport slave (
    input  wr, d, rd,
`ifdef MAXHPC_FIFO_SC_PKT_EN
    input  commit, discard,
`endif
    output q, empty, full, usedw, almost_full, almost_empty, ovf, udf
  );
endinterface
`default_nettype wire

// File: rtl/maxhpc_fifo_sc.sv
`default_nettype none
// ============================================================================
//  Module      : maxhpc_fifo_sc
//  Description : Single-clock synchronous FIFO with registered fill count,
//                programmable almost-full/almost-empty flags, sticky
//                overflow/underflow flags and optional show-ahead output.
//  Ports       : clk   - single clock, all logic on the rising edge
//                clr   - synchronous active-high reset
//                fifo  - maxhpc_fifo_sc_if.slave (wr/d/rd in, q and status out)
//  Options     : define MAXHPC_FIFO_SC_PKT_EN for packet commit/discard mode.
//  Revision    : 1.0  initial release
// ============================================================================
module maxhpc_fifo_sc #(
  parameter int    DEPTH_WD  = 4,
  parameter int    DATA_WD   = 8,
  parameter string SHOWAHEAD = "OFF",
  parameter int    AF_LVL    = 2**DEPTH_WD - 2,
  parameter int    AE_LVL    = 1,
  parameter string USE_EAB   = "ON"
) (
  input  logic             clk,
  input  logic             clr,
  maxhpc_fifo_sc_if.slave  fifo
);

  localparam bit                c_SA    = (SHOWAHEAD == "ON");
  localparam int                c_DEPTH = 2**DEPTH_WD;
  localparam logic [DEPTH_WD:0] c_CAP   = {1'b1, {DEPTH_WD{1'b0}}};
  localparam logic [DEPTH_WD:0] c_AF    = AF_LVL[DEPTH_WD:0];
  localparam logic [DEPTH_WD:0] c_AE    = AE_LVL[DEPTH_WD:0];
  localparam logic [DEPTH_WD:0] c_ZERO  = '0;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  // r_wptr is the tentative write pointer, r_cptr the committed one; without
  // packet mode they always move together.
  logic [DEPTH_WD:0]   r_wptr;
  logic [DEPTH_WD:0]   r_cptr;
  logic [DEPTH_WD:0]   r_rptr;
  logic [DEPTH_WD:0]   r_usedw;
  logic                r_empty;
  logic                r_full;
  logic                r_af;
  logic                r_ae;
  logic                r_ovf;
  logic                r_udf;
  logic                r_qv;      // show-ahead: r_q holds a valid head word
  logic [DATA_WD-1:0]  r_q;

  logic                w_wa;
  logic                w_ra;
  logic                w_commit;
  logic                w_discard;
  logic                w_fetch;
  logic                w_rd_en;
  logic                w_qv_nxt;
  logic [DEPTH_WD:0]   w_avail;
  logic [DEPTH_WD:0]   w_wptr_inc;
  logic [DEPTH_WD:0]   w_wptr_nxt;
  logic [DEPTH_WD:0]   w_cptr_nxt;
  logic [DEPTH_WD:0]   w_rptr_nxt;
  logic [DEPTH_WD:0]   w_qv_ext;
  logic [DEPTH_WD:0]   w_used_nxt;
  logic [DEPTH_WD:0]   w_cused_nxt;
  logic                w_empty_nxt;
  logic [DEPTH_WD-1:0] w_waddr;
  logic [DEPTH_WD-1:0] w_raddr;

`ifdef MAXHPC_FIFO_SC_PKT_EN
  assign w_commit  = fifo.commit;
  assign w_discard = fifo.discard;
`else
  // Every accepted write is committed in the cycle it is accepted.
  assign w_commit  = 1'b1;
  assign w_discard = 1'b0;
`endif

  assign w_wa    = fifo.wr && !r_full;
  assign w_ra    = fifo.rd && !r_empty;
  assign w_waddr = r_wptr[DEPTH_WD-1:0];
  assign w_raddr = r_rptr[DEPTH_WD-1:0];

  // Committed words still in RAM (excludes the show-ahead register and any
  // word being written this cycle, so the RAM read never races the write).
  assign w_avail = r_cptr - r_rptr;

  // Show-ahead refill: load the output register whenever it is empty or is
  // being popped, giving back-to-back words with no bubble.
  assign w_fetch = c_SA && (w_avail != c_ZERO) && (!r_qv || w_ra);
  assign w_rd_en = c_SA ? w_fetch : w_ra;

  assign w_wptr_inc = r_wptr + {{DEPTH_WD{1'b0}}, w_wa};
  assign w_wptr_nxt = w_discard ? r_cptr : w_wptr_inc;
  assign w_cptr_nxt = w_discard ? r_cptr : (w_commit ? w_wptr_inc : r_cptr);
  assign w_rptr_nxt = r_rptr + {{DEPTH_WD{1'b0}}, w_rd_en};

  assign w_qv_nxt = c_SA && (w_fetch || (r_qv && !w_ra));
  assign w_qv_ext = {{DEPTH_WD{1'b0}}, w_qv_nxt};

  // In show-ahead mode the word parked in r_q is still counted as stored.
  assign w_used_nxt  = w_wptr_nxt - w_rptr_nxt + w_qv_ext;
  assign w_cused_nxt = w_cptr_nxt - w_rptr_nxt + w_qv_ext;
  assign w_empty_nxt = c_SA ? !w_qv_nxt : (w_cused_nxt == c_ZERO);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wptr  <= '0;
      r_cptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_qv    <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_cptr  <= w_cptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_usedw <= w_used_nxt;
      r_empty <= w_empty_nxt;
      r_full  <= (w_used_nxt == c_CAP);
      r_af    <= (w_used_nxt >= c_AF);
      r_ae    <= (w_cused_nxt <= c_AE);
      r_qv    <= w_qv_nxt;
      if (fifo.wr && r_full) begin
        r_ovf <= 1'b1;
      end
      if (fifo.rd && r_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Storage with registered read port; r_q is the RAM output register and,
  // in show-ahead mode, doubles as the prefetch register.
  generate
    if (USE_EAB == "ON") begin : g_eab
      logic [DATA_WD-1:0] r_mem [0:c_DEPTH-1];

      always_ff @(posedge clk) begin
        if (w_wa) begin
          r_mem[w_waddr] <= fifo.d;
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          r_q <= '0;
        end else if (w_rd_en) begin
          r_q <= r_mem[w_raddr];
        end
      end
    end else begin : g_lut
      // Flop-based storage; cleared with the FIFO so no stale data survives.
      logic [DATA_WD-1:0] r_mem [0:c_DEPTH-1];

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else if (w_wa) begin
          r_mem[w_waddr] <= fifo.d;
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          r_q <= '0;
        end else if (w_rd_en) begin
          r_q <= r_mem[w_raddr];
        end
      end
    end
  endgenerate

  assign fifo.q            = r_q;
  assign fifo.empty        = r_empty;
  assign fifo.full         = r_full;
  assign fifo.usedw        = r_usedw;
  assign fifo.almost_full  = r_af;
  assign fifo.almost_empty = r_ae;
  assign fifo.ovf          = r_ovf;
  assign fifo.udf          = r_udf;

endmodule
`default_nettype wire
